// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the byte-serial adder sequencer
package adder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_width(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/csa8_core.sv
// rtl/csa8_core.sv - 8-bit carry-skip adder: two 4-bit ripple blocks with a skip mux each
module csa8_core
  import adder_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout,
  output logic              c6
);

  logic [BYTE_W-1:0] p;
  logic [BYTE_W-1:0] g;
  logic [4:0]        lo_c;
  logic [4:0]        hi_c;
  logic              c4;

  assign p = a ^ b;
  assign g = a & b;

  // A block whose bits all propagate passes its carry-in straight through.
  always_comb begin
    lo_c    = '0;
    hi_c    = '0;
    lo_c[0] = cin;
    for (int i = 0; i < 4; i++) lo_c[i+1] = g[i] | (p[i] & lo_c[i]);
    c4      = (&p[3:0]) ? cin : lo_c[4];
    hi_c[0] = c4;
    for (int i = 0; i < 4; i++) hi_c[i+1] = g[i+4] | (p[i+4] & hi_c[i]);
    cout    = (&p[7:4]) ? c4 : hi_c[4];
    c6      = hi_c[3];
    sum     = p ^ {hi_c[3:0], lo_c[3:0]};
  end

endmodule

// File: rtl/byte_serial_add_seq.sv
// rtl/byte_serial_add_seq.sv - wide add (and subtract with BYTE_SERIAL_ADD_SUB_EN) one byte per clock, LSB first
module byte_serial_add_seq
  import adder_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] op_a,
  input  logic [BYTE_W*NBYTES-1:0] op_b,
  input  logic                     op_sub,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     carry_out,
  output logic                     overflow
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = idx_width(NBYTES);
  localparam int SW = IW + 3;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     idx;
  logic [SW-1:0]     bit_base;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic              carry;
  logic              accept;
  logic              last_byte;
  logic              init_carry;
  logic [BYTE_W-1:0] a_byte;
  logic [BYTE_W-1:0] b_byte;
  logic [BYTE_W-1:0] sum_byte;
  logic              core_cout;
  logic              core_c6;

  assign accept    = (state == IDLE) && start;
  assign last_byte = (idx == LAST_IDX);
  assign bit_base  = {idx, 3'b000};
  assign a_byte    = a_reg[bit_base +: BYTE_W];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef BYTE_SERIAL_ADD_SUB_EN
  logic sub_reg;

  always_ff @(posedge clk) begin
    if (rst)         sub_reg <= 1'b0;
    else if (accept) sub_reg <= op_sub;
  end

  // Subtract is A + ~B + 1: invert B bytes and seed the carry with 1.
  assign b_byte     = sub_reg ? ~b_reg[bit_base +: BYTE_W] : b_reg[bit_base +: BYTE_W];
  assign init_carry = op_sub;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_byte        = b_reg[bit_base +: BYTE_W];
  assign init_carry    = 1'b0;
`endif

  csa8_core u_core (
    .a    (a_byte),
    .b    (b_byte),
    .cin  (carry),
    .sum  (sum_byte),
    .cout (core_cout),
    .c6   (core_c6)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     if (last_byte) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      idx       <= '0;
      a_reg     <= op_a;
      b_reg     <= op_b;
      carry     <= init_carry;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == ADD) begin
      result[bit_base +: BYTE_W] <= sum_byte;
      carry <= core_cout;
      idx   <= last_byte ? '0 : idx + 1'b1;
      if (last_byte) begin
        overflow  <= core_c6 ^ core_cout;
        carry_out <= core_cout;
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// tb/tb_byte_serial_add_seq.sv - randomized and directed bench for byte_serial_add_seq (honours BYTE_SERIAL_ADD_SUB_EN)
module tb_byte_serial_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_sub = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  byte_serial_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    int           acc_cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ph = 0;
  int   n_done = 0;
  int   n_done_exp = 0;

  // Full-width arithmetic reference: the result of an accepted op.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sb, input int c);
    exp_t       e;
    logic       s;
    logic [W:0] t;
`ifdef BYTE_SERIAL_ADD_SUB_EN
    s = sb;
`else
    s = sb & 1'b0;
`endif
    if (s) begin
      e.r = a - b;
      e.c = (a >= b);
      e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
    end else begin
      t   = {1'b0, a} + {1'b0, b};
      e.r = t[W-1:0];
      e.c = t[W];
      e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
    end
    e.acc_cyc = c;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the phase model at the edge, check 1 time unit later.
  task automatic step(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sb, input logic r);
    exp_t e;
    start  = s;
    op_a   = a;
    op_b   = b;
    op_sub = sb;
    rst    = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      ph = 0;
      q.delete();
    end else if (ph == 0) begin
      if (s) begin
        ph = 1;
        q.push_back(model(a, b, sb, cyc));
      end
    end else if (ph == NB + 1) begin
      ph = 0;
    end else begin
      ph++;
    end
    #1;
    chk("busy", W'(busy), W'(ph != 0));
    chk("done", W'(done), W'(ph == NB + 1));
    if (done === 1'b1) n_done++;
    if (r) begin
      chk("rst_result", result, '0);
      chk("rst_carry_out", W'(carry_out), '0);
      chk("rst_overflow", W'(overflow), '0);
    end
    if (ph == NB + 1) begin
      n_done_exp++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", result, e.r);
        chk("carry_out", W'(carry_out), W'(e.c));
        chk("overflow", W'(overflow), W'(e.v));
        chk("latency", W'(cyc - e.acc_cyc), W'(NB));
      end else begin
        chk("model_queue", W'(0), W'(1));
      end
    end
  endtask

  task automatic idle_step();
    step(1'b0, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
    step(1'b1, a, b, sb, 1'b0);
    repeat (NB + 1) idle_step();
  endtask

  initial begin
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);

    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    chk("ff_plus_1", result, 32'h0000_0100);
    chk("ff_plus_1_c", W'(carry_out), '0);
    chk("ff_plus_1_v", W'(overflow), '0);

    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    chk("ripple_all", result, 32'h0000_0000);
    chk("ripple_all_c", W'(carry_out), W'(1));
    chk("ripple_all_v", W'(overflow), '0);

    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    chk("pos_ovf", result, 32'h8000_0000);
    chk("pos_ovf_c", W'(carry_out), '0);
    chk("pos_ovf_v", W'(overflow), W'(1));

    run_op(32'h0000_0005, 32'h0000_0007, 1'b1);
`ifdef BYTE_SERIAL_ADD_SUB_EN
    chk("sub_5_7", result, 32'hFFFF_FFFE);
`else
    chk("sub_5_7", result, 32'h0000_000C);
`endif
    chk("sub_5_7_c", W'(carry_out), '0);

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));

    // start held high: only IDLE cycles accept, operands change every cycle
    repeat (30) step(1'b1, W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    repeat (NB + 2) idle_step();

    // reset in the second ADD cycle abandons the operation
    step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
    idle_step();
    step(1'b0, W'($urandom), W'($urandom), 1'b0, 1'b1);
    repeat (NB + 3) idle_step();
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    chk("after_rst", result, 32'h2222_2221);

    chk("done_count", W'(n_done), W'(n_done_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
